// File: rtl/tdc_event_reader_if.sv
// TDC event bus shared by the TDC core and the external event reader.
// The core presents one event (timestamp, ToT, channel) with hasEvent held
// high until the reader pulses clear.
interface TDCInterface;
  logic [31:0] timestamp;
  logic [31:0] timeOverThreshold;
  logic [3:0]  chan;
  logic        hasEvent;
  logic        clear;

  modport core (
    output timestamp, timeOverThreshold, chan, hasEvent,
    input  clear
  );

  modport external (
    input  timestamp, timeOverThreshold, chan, hasEvent,
    output clear
  );
endinterface

// File: rtl/tdc_event_reader.sv
// tdc_event_reader: captures events from the TDC bus, releases the TDC with a
// one-cycle clear pulse, buffers events in a small FIFO, and serializes each
// one as three 32-bit words (header, timestamp, ToT) on a valid/ready stream.
// Optional feature macro: TDC_READER_DROP_CNT_EN -- when defined, an event
// arriving while the FIFO is full is cleared and discarded, and counted on
// dropped_count; when undefined, such an event is left in the TDC.
module tdc_event_reader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER_TAG = 8'hEA
) (
  input  logic                          clk,
  input  logic                          reset_n,
  TDCInterface.external                 tdc,
  input  logic                          enable,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef TDC_READER_DROP_CNT_EN
  ,
  output logic [15:0]                   dropped_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  chan;
    logic [31:0] ts;
    logic [31:0] tot;
  } entry_t;

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_LOW} cap_state_t;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TS, S_TOT} ser_state_t;

  entry_t     mem_q [FIFO_DEPTH];
  entry_t     head;

  cap_state_t cap_state_q, cap_state_d;
  logic       clear_q, clear_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  ser_state_t ser_state_q, ser_state_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [31:0] cur_ts_q, cur_ts_d;
  logic [31:0] cur_tot_q, cur_tot_d;

  logic push, pop, full, empty;

`ifdef TDC_READER_DROP_CNT_EN
  logic        drop;
  logic [15:0] dropped_q, dropped_d;
`endif

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Capture FSM: take an event on the first edge hasEvent is seen, pulse clear,
  // then wait for hasEvent to fall so a slow TDC is not captured twice.
  always_comb begin
    cap_state_d = cap_state_q;
    clear_d     = 1'b0;
    push        = 1'b0;
`ifdef TDC_READER_DROP_CNT_EN
    drop        = 1'b0;
`endif
    case (cap_state_q)
      IDLE: begin
        if (enable && tdc.hasEvent) begin
          if (!full) begin
            push        = 1'b1;
            clear_d     = 1'b1;
            cap_state_d = CLEAR;
          end
`ifdef TDC_READER_DROP_CNT_EN
          else begin
            drop        = 1'b1;
            clear_d     = 1'b1;
            cap_state_d = CLEAR;
          end
`endif
        end
      end
      CLEAR:    cap_state_d = WAIT_LOW;
      WAIT_LOW: if (!tdc.hasEvent) cap_state_d = IDLE;
      default:  cap_state_d = IDLE;
    endcase
  end

  // Serializer FSM: pop an event, then present header / timestamp / ToT, each
  // held until accepted; back-to-back events follow with no idle cycle.
  always_comb begin
    ser_state_d = ser_state_q;
    seq_d       = seq_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cur_ts_d    = cur_ts_q;
    cur_tot_d   = cur_tot_q;
    pop         = 1'b0;
    case (ser_state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_HDR: begin
        if (out_ready) begin
          out_data_d  = cur_ts_q;
          ser_state_d = S_TS;
        end
      end
      S_TS: begin
        if (out_ready) begin
          out_data_d  = cur_tot_q;
          out_last_d  = 1'b1;
          ser_state_d = S_TOT;
        end
      end
      S_TOT: begin
        if (out_ready) begin
          seq_d      = seq_q + 16'd1;
          out_last_d = 1'b0;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            out_data_d  = 32'd0;
            ser_state_d = S_IDLE;
          end
        end
      end
      default: ser_state_d = S_IDLE;
    endcase
    // Loading a popped event always emits its header with the (possibly
    // just incremented) sequence number.
    if (pop) begin
      cur_ts_d    = head.ts;
      cur_tot_d   = head.tot;
      out_data_d  = {HEADER_TAG, head.chan, 4'b0000, seq_d};
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      ser_state_d = S_HDR;
    end
  end

  // FIFO pointer and occupancy bookkeeping; push and pop may coincide.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
`ifdef TDC_READER_DROP_CNT_EN
    dropped_d = (drop && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
`endif
  end

  // Event storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{chan: tdc.chan, ts: tdc.timestamp, tot: tdc.timeOverThreshold};
  end

  // All control state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_state_q <= IDLE;
      clear_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ser_state_q <= S_IDLE;
      seq_q       <= 16'd0;
      out_data_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cur_ts_q    <= 32'd0;
      cur_tot_q   <= 32'd0;
`ifdef TDC_READER_DROP_CNT_EN
      dropped_q   <= 16'd0;
`endif
    end else begin
      cap_state_q <= cap_state_d;
      clear_q     <= clear_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ser_state_q <= ser_state_d;
      seq_q       <= seq_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cur_ts_q    <= cur_ts_d;
      cur_tot_q   <= cur_tot_d;
`ifdef TDC_READER_DROP_CNT_EN
      dropped_q   <= dropped_d;
`endif
    end
  end

  assign tdc.clear  = clear_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign fifo_count = count_q;
`ifdef TDC_READER_DROP_CNT_EN
  assign dropped_count = dropped_q;
`endif

endmodule
